// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: default sizes, exception flag positions and stage indices for ctrl_pipe.
package ctrl_pipe_pkg;
    localparam int DEF_W       = 27;
    localparam int DEF_STAGES  = 3;
    localparam int EXC_BREAK   = 3;
    localparam int EXC_SYSCALL = 2;
    localparam int EXC_ERET    = 1;
    localparam int EXC_RESERVE = 0;
    localparam int STG_E       = 0;
    localparam int STG_M       = 1;
    localparam int STG_W       = 2;
endpackage

// File: rtl/ctrl_pipe_stage.sv
// ctrl_pipe_stage: one valid+control register with clr > hold > bubble > load priority.
module ctrl_pipe_stage #(
    parameter int W = 27
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         hold,
    input  logic         bubble,
    input  logic         src_valid,
    input  logic [W-1:0] src_data,
    output logic         valid,
    output logic [W-1:0] data
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clr) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (!hold) begin
            // invalid words always carry zero control bits
            valid <= bubble ? 1'b0 : src_valid;
            data  <= (bubble || !src_valid) ? '0 : src_data;
        end
    end
endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: parametrised E/M/W control pipeline with stall propagation, bubbles, flush and exception squash.
// Optional performance counters are built when CTRL_PIPE_PERF_EN is defined.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int STAGES    = DEF_STAGES,
    parameter int EXC_STAGE = 1,
    parameter int EXC_BITS  = 4,
    parameter int EXC_LSB   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [W-1:0]          in_data,
    output logic                  in_ready,
    input  logic [STAGES-1:0]     stall,
    input  logic [STAGES-1:0]     flush,
    output logic [STAGES-1:0]     out_valid,
    output logic [STAGES*W-1:0]   out_data,
    output logic                  exc_req,
    output logic                  exc_pulse,
    output logic [EXC_BITS-1:0]   exc_cause,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_bubble_cnt
);
    logic [STAGES-1:0] stall_eff, clr, bub, src_valid;
    logic [W-1:0]      src_data [STAGES];
    logic [W-1:0]      data_q   [STAGES];
    logic [EXC_BITS-1:0] flags;

    assign flags    = data_q[EXC_STAGE][EXC_LSB +: EXC_BITS];
    assign exc_req  = out_valid[EXC_STAGE] & (|flags) & ~stall_eff[EXC_STAGE];
    assign in_ready = ~stall_eff[0];

    for (genvar i = 0; i < STAGES; i++) begin : g_stg
        assign stall_eff[i] = |stall[STAGES-1:i];
        assign clr[i]       = flush[i] | (exc_req & (i <= EXC_STAGE));
        if (i == 0) begin : g_head
            assign bub[i]       = 1'b0;
            assign src_valid[i] = in_valid;
            assign src_data[i]  = in_data;
        end else begin : g_body
            assign bub[i]       = stall_eff[i-1];
            // the excepting word must never advance past the commit stage
            assign src_valid[i] = out_valid[i-1] & ~(exc_req & ((i - 1) == EXC_STAGE));
            assign src_data[i]  = data_q[i-1];
        end
        ctrl_pipe_stage #(.W(W)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr[i]),
            .hold      (stall_eff[i]),
            .bubble    (bub[i]),
            .src_valid (src_valid[i]),
            .src_data  (src_data[i]),
            .valid     (out_valid[i]),
            .data      (data_q[i])
        );
        assign out_data[i*W +: W] = data_q[i];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exc_pulse <= 1'b0;
            exc_cause <= '0;
        end else begin
            exc_pulse <= exc_req;
            if (exc_req)
                exc_cause <= flags & (~flags + 1'b1);
        end
    end

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] stall_cnt, bubble_cnt, bubbles;
    logic [32:0] bubble_sum;
    always_comb begin
        bubbles = '0;
        for (int i = 1; i < STAGES; i++)
            bubbles = bubbles + 32'(bub[i] & ~stall_eff[i] & ~clr[i]);
    end
    assign bubble_sum = {1'b0, bubble_cnt} + {1'b0, bubbles};
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            stall_cnt  <= (stall_eff[0] && stall_cnt != '1) ? stall_cnt + 32'd1 : stall_cnt;
            bubble_cnt <= bubble_sum[32] ? '1 : bubble_sum[31:0];
        end
    end
    assign perf_stall_cnt  = stall_cnt;
    assign perf_bubble_cnt = bubble_cnt;
`else
    assign perf_stall_cnt  = '0;
    assign perf_bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed self-checking bench for ctrl_pipe (default parameters).
module tb_ctrl_pipe;
    import ctrl_pipe_pkg::*;
    localparam int W = 27;
    localparam int S = 3;
`ifdef CTRL_PIPE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic           in_ready;
    logic [S-1:0]   stall, flush, out_valid;
    logic [S*W-1:0] out_data;
    logic           exc_req, exc_pulse;
    logic [3:0]     exc_cause;
    logic [31:0]    perf_stall_cnt, perf_bubble_cnt;
    int errs = 0;
    int checks = 0;

    ctrl_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .stall(stall), .flush(flush), .out_valid(out_valid), .out_data(out_data),
        .exc_req(exc_req), .exc_pulse(exc_pulse), .exc_cause(exc_cause),
        .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] stg(int i);
        return out_data[i*W +: W];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; stall = '0; flush = '0;
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_pulse", exc_pulse, 0);
        chk("rst_cause", exc_cause, 0);
        chk("rst_perf", {perf_stall_cnt, perf_bubble_cnt}, 0);
        tick; tick;
        rst = 1'b1;
        // stream 0x10..0x50 (low nibble clear so no exception flags)
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1; in_data = W'(k * 16);
            tick;
            if (k == 3) begin
                chk("lat_s2", stg(STG_W), 27'h10);
                chk("lat_s1", stg(STG_M), 27'h20);
                chk("lat_s0", stg(STG_E), 27'h30);
                chk("lat_valid", out_valid, 3'b111);
            end
        end
        chk("stream_s2", stg(2), 27'h30);
        chk("stream_valid", out_valid, 3'b111);
        // hold stage 1: upstream freezes, stage 2 bubbles twice
        stall = 3'b010; in_data = 27'h60;
        #1;
        chk("stall_ready", in_ready, 0);
        for (int k = 0; k < 2; k++) begin
            tick;
            chk("stall_s0", stg(0), 27'h50);
            chk("stall_s1", stg(1), 27'h40);
            chk("stall_s2_bub", {out_valid[2], stg(2)}, 0);
        end
        stall = '0;
        tick;
        chk("resume", {stg(0), stg(1), stg(2)}, {27'h60, 27'h50, 27'h40});
        chk("perf_bub", perf_bubble_cnt, PERF ? 2 : 0);
        chk("perf_stall", perf_stall_cnt, PERF ? 2 : 0);
        // syscall word reaches stage 1 unstalled
        in_data = 27'h104;
        tick;
        in_valid = 1'b0; in_data = '0;
        tick;
        chk("exc_at_s1", stg(1), 27'h104);
        in_valid = 1'b1; in_data = 27'h70;
        #1;
        chk("exc_req", exc_req, 1);
        tick;
        chk("exc_squash", out_valid[1:0], 2'b00);
        chk("exc_not_s2", stg(2) !== 27'h104, 1);
        chk("exc_pulse", exc_pulse, 1);
        chk("exc_cause", exc_cause, 4'b0100);
        chk("exc_req_off", exc_req, 0);
        in_valid = 1'b0; in_data = '0;
        tick;
        chk("pulse_once", exc_pulse, 0);
        chk("cause_held", exc_cause, 4'b0100);
        // break+reserve word stalled at stage 1: commit deferred to release edge
        in_valid = 1'b1; in_data = 27'h109;
        tick;
        in_valid = 1'b0; in_data = '0;
        tick;
        stall = 3'b010;
        #1;
        chk("exc_stalled", exc_req, 0);
        tick;
        chk("exc_held_s1", {out_valid[1], stg(1)}, {1'b1, 27'h109});
        chk("no_pulse_stalled", exc_pulse, 0);
        stall = '0;
        #1;
        chk("exc_release", exc_req, 1);
        tick;
        chk("exc2_squash", out_valid[1:0], 2'b00);
        chk("exc2_not_s2", stg(2) !== 27'h109, 1);
        chk("exc2_pulse", exc_pulse, 1);
        chk("exc2_cause", exc_cause, 4'b0001);
        chk("perf_bub2", perf_bubble_cnt, PERF ? 3 : 0);
        chk("perf_stall2", perf_stall_cnt, PERF ? 3 : 0);
        // flush stage 0 while stage 1 is free: stage 1 still receives old word
        in_valid = 1'b1; in_data = 27'h80;
        tick;
        in_valid = 1'b0; in_data = '0; flush = 3'b001;
        tick;
        flush = '0;
        chk("flush_s1", {out_valid[1], stg(1)}, {1'b1, 27'h80});
        chk("flush_s0", {out_valid[0], stg(0)}, 0);
        // asynchronous reset mid-stream
        in_valid = 1'b1; in_data = 27'h90;
        tick;
        in_data = 27'hA0;
        tick;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_cause", {exc_pulse, exc_cause}, 0);
        tick;
        rst = 1'b1; in_valid = 1'b1; in_data = 27'hB0;
        tick;
        in_valid = 1'b0; in_data = '0;
        tick;
        chk("arst_pre", out_valid[2], 0);
        tick;
        chk("arst_lat", {out_valid[2], stg(2)}, {1'b1, 27'hB0});
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
